pll_lock_sequencer: RTL and testbench
=====================================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 500, meaning pll_rst pulse width in init_clk cycles (10 us at 50 MHz).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 100000, meaning the maximum number of cycles to wait for lock per attempt.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024, meaning the number of consecutive locked cycles required before lock is declared.
REQ-004 The block SHALL have parameter ICP_MIN, default 6'd1, meaning the first charge-pump code tried.
REQ-005 The block SHALL have parameter ICP_MAX, default 6'd32, meaning the last charge-pump code tried; ICP_MIN <= ICP_MAX is required.
REQ-006 The block SHALL have parameter LPFRES, default 3'd2, meaning the fixed loop-filter resistor code.
REQ-007 init_clk  in  1  The block's only clock, free-running and independent of the PLL.
REQ-008 rstn  in  1  Asynchronous active-low reset.
REQ-009 pll_lock  in  1  Raw PLL lock, asynchronous to init_clk.
REQ-010 pll_rst  out  1  PLL reset, active-high.
REQ-011 icpsel  out  6  Charge-pump current code to the PLL.
REQ-012 lpfres  out  3  Loop-filter resistor code to the PLL.
REQ-013 lock  out  1  Qualified, stable lock indication.
REQ-014 user_rst_n  out  1  Downstream active-low reset; equals ~lock, registered.
REQ-015 fail  out  1  Sticky flag: all codes exhausted without lock.
REQ-016 relock_cnt  out  8  Count of lock losses after LOCKED, saturating at 255.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer (lock_s), giving 2 cycles of latency.
REQ-018 The FSM SHALL have exactly these states: RESET_PLL, WAIT_LOCK, STABLE, LOCKED, FAIL.
REQ-019 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
REQ-020 WAIT_LOCK: pll_rst=0; if lock_s=1, go to STABLE; otherwise, when the timer reaches LOCK_TIMEOUT-1, go to the next-attempt rule.
REQ-021 Next-attempt rule: if icpsel==ICP_MAX, go to FAIL; otherwise increment icpsel by 1 and go to RESET_PLL.
REQ-022 STABLE: count consecutive cycles with lock_s=1; on count==STABLE_CYCLES go to LOCKED; if lock_s=0 on any cycle, go to RESET_PLL with icpsel unchanged.
REQ-023 LOCKED: lock=1 and user_rst_n=1; on lock_s=0, in the same edge: lock=0, user_rst_n=0, relock_cnt++ (saturating), go to RESET_PLL with icpsel unchanged.
REQ-024 FAIL: pll_rst=0, fail=1, lock=0; remain in FAIL until rstn is asserted.
REQ-025 lpfres SHALL equal LPFRES constantly.
REQ-026 lock and user_rst_n SHALL be registered outputs, asserted only in LOCKED.
REQ-027 The timer SHALL be wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and SHALL be cleared on every state entry.

Reset
REQ-028 While rstn=0: state=RESET_PLL, timer=0, pll_rst=1, icpsel=ICP_MIN, lpfres=LPFRES, lock=0, user_rst_n=0, fail=0, relock_cnt=0, synchronizer flops=0.
REQ-029 Assertion of rstn in any state (including mid-attempt) SHALL restore the values of REQ-028 asynchronously.
REQ-030 After rstn release, the first RESET_PLL pulse SHALL last exactly RST_CYCLES cycles.

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state enum and the default parameter constants.
REQ-032 The synchronizer SHALL be the sub-module sync2 (reset value 0); all other logic SHALL be in one module of 120-250 lines.

Verification (bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, ICP_MIN=2, ICP_MAX=4)
REQ-033 Scenario 1: pll_lock rises 3 cycles after pll_rst falls and stays high -> lock=1 exactly 2+8 cycles after the pll_lock rise; icpsel=2; fail=0.
REQ-034 Scenario 2: pll_lock held at 0 -> 3 pll_rst pulses of 4 cycles each with icpsel 2, 3, 4 -> fail=1, pll_rst=0, icpsel=4, lock=0.
REQ-035 Scenario 3: pll_lock follows pll_rst low only while icpsel==3 -> LOCKED with icpsel=3 after exactly one timeout.
REQ-036 Scenario 4: a 1-cycle low glitch on pll_lock during STABLE -> new 4-cycle pll_rst pulse with icpsel unchanged; lock stays 0.
REQ-037 Scenario 5: pll_lock falls in LOCKED -> lock=0 and user_rst_n=0 3 cycles later, relock_cnt=1; 260 repeated losses -> relock_cnt=255.
REQ-038 Scenario 6: rstn pulsed low mid-WAIT_LOCK with icpsel=3 -> immediately pll_rst=1, icpsel=2, all flags 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    LOCKED,
    FAIL
  } seq_state_t;

  localparam int unsigned DEF_RST_CYCLES    = 500;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 100000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam logic [5:0]  DEF_ICP_MIN       = 6'd1;
  localparam logic [5:0]  DEF_ICP_MAX       = 6'd32;
  localparam logic [2:0]  DEF_LPFRES        = 3'd2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for lock, qualifies it and
// steps through charge-pump codes until lock is achieved or all codes fail.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic [5:0]  ICP_MIN       = DEF_ICP_MIN,
  parameter logic [5:0]  ICP_MAX       = DEF_ICP_MAX,
  parameter logic [2:0]  LPFRES        = DEF_LPFRES
) (
  input  logic       init_clk,
  input  logic       rstn,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic       lock,
  output logic       user_rst_n,
  output logic       fail,
  output logic [7:0] relock_cnt
);

  localparam int unsigned TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s counts as locked cycle 1,
  // so STABLE itself needs STABLE_CYCLES-1 more cycles (timer 0..SC-2).
  localparam logic [TW-1:0] STABLE_LAST  = TW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);

  seq_state_t    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [5:0]    icp_nxt;
  logic          relock_evt;
  logic          lock_s;

  sync2 u_lock_sync (
    .clk   (init_clk),
    .rst_n (rstn),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign lpfres = LPFRES;

  always_comb begin
    state_nxt  = state;
    icp_nxt    = icpsel;
    relock_evt = 1'b0;
    timer_nxt  = '0;

    case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          if (icpsel == ICP_MAX) begin
            state_nxt = FAIL;
          end else begin
            icp_nxt   = icpsel + 6'd1;
            state_nxt = RESET_PLL;
          end
        end
      end
      STABLE: begin
        if (!lock_s)                     state_nxt = RESET_PLL;
        else if (timer == STABLE_LAST)   state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!lock_s) begin
          state_nxt  = RESET_PLL;
          relock_evt = 1'b1;
        end
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = RESET_PLL;
    endcase

    // Timer restarts on every state entry and idles in the terminal states.
    if (state_nxt == state && state != LOCKED && state != FAIL)
      timer_nxt = timer + 1'b1;
  end

  always_ff @(posedge init_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RESET_PLL;
      timer      <= '0;
      icpsel     <= ICP_MIN;
      pll_rst    <= 1'b1;
      lock       <= 1'b0;
      user_rst_n <= 1'b0;
      fail       <= 1'b0;
      relock_cnt <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      icpsel     <= icp_nxt;
      pll_rst    <= (state_nxt == RESET_PLL);
      lock       <= (state_nxt == LOCKED);
      user_rst_n <= (state_nxt == LOCKED);
      fail       <= (state_nxt == FAIL);
      if (relock_evt && relock_cnt != '1)
        relock_cnt <= relock_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

  logic       init_clk = 1'b0;
  logic       rstn;
  logic       pll_lock;
  logic       pll_lock_man;
  logic       follow;
  logic       pll_rst;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic       lock;
  logic       user_rst_n;
  logic       fail;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  always #5 init_clk = ~init_clk;

  // In follow mode the model PLL locks whenever it is out of reset with icpsel==3.
  assign pll_lock = follow ? (!pll_rst && icpsel == 6'd3) : pll_lock_man;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (16),
    .STABLE_CYCLES (8),
    .ICP_MIN       (6'd2),
    .ICP_MAX       (6'd4),
    .LPFRES        (3'd5)
  ) dut (
    .init_clk   (init_clk),
    .rstn       (rstn),
    .pll_lock   (pll_lock),
    .pll_rst    (pll_rst),
    .icpsel     (icpsel),
    .lpfres     (lpfres),
    .lock       (lock),
    .user_rst_n (user_rst_n),
    .fail       (fail),
    .relock_cnt (relock_cnt)
  );

  typedef struct {
    logic        rstn;
    logic        pll_lock;
    int          n;
    logic        exp_rst;
    logic [5:0]  exp_icp;
    logic        exp_lock;
    logic        exp_urn;
    logic        exp_fail;
    logic [7:0]  exp_rc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns the width of the next pll_rst pulse in cycles.
  task automatic measure_pulse(input string name, output int width, output logic [5:0] icp);
    int guard;
    guard = 0;
    width = 0;
    icp   = '0;
    while (pll_rst !== 1'b1 && guard < 200) begin
      @(negedge init_clk);
      guard++;
    end
    if (pll_rst !== 1'b1) begin
      check({name, "_pulse_timeout"}, 32'(pll_rst), 32'd1);
    end else begin
      icp = icpsel;
      while (pll_rst === 1'b1 && width < 100) begin
        width++;
        @(negedge init_clk);
      end
    end
  endtask

  task automatic wait_lock_val(input logic v, input int limit, input string name, output int n);
    n = 0;
    while (lock !== v && n <= limit) begin
      @(negedge init_clk);
      n++;
    end
    if (lock !== v) check({name, "_timeout"}, 32'(lock), 32'(v));
  endtask

  initial begin
    int          w, n, guard;
    logic [5:0]  icp;
    logic [20:0] act, exp;

    //              rstn  lock  n  rst  icp    lock  urn   fail  rc
    vecs[0]  = '{1'b0, 1'b0, 2, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 3, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 3, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 9, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 5, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 2, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 1, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b1, 1'b0, 3, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0};

    follow       = 1'b0;
    pll_lock_man = 1'b0;
    rstn         = 1'b0;
    @(negedge init_clk);

    // Reset state, first lock, first loss and async reset.
    foreach (vecs[i]) begin
      rstn         = vecs[i].rstn;
      pll_lock_man = vecs[i].pll_lock;
      repeat (vecs[i].n) @(negedge init_clk);
      #1;
      act = {pll_rst, icpsel, lock, user_rst_n, fail, relock_cnt, lpfres};
      exp = {vecs[i].exp_rst, vecs[i].exp_icp, vecs[i].exp_lock, vecs[i].exp_urn,
             vecs[i].exp_fail, vecs[i].exp_rc, 3'd5};
      check($sformatf("vec%0d", i), 32'(act), 32'(exp));
    end

    // No lock ever: three pulses with icpsel 2,3,4 then FAIL.
    @(negedge init_clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      measure_pulse("nolock", w, icp);
      check($sformatf("nolock_width%0d", k), 32'(w), 32'd4);
      check($sformatf("nolock_icp%0d", k), 32'(icp), 32'(2 + k));
    end
    guard = 0;
    while (fail !== 1'b1 && guard < 40) begin
      @(negedge init_clk);
      guard++;
    end
    check("nolock_fail", 32'(fail), 32'd1);
    check("nolock_state", 32'({pll_rst, icpsel, lock, user_rst_n}), 32'({1'b0, 6'd4, 1'b0, 1'b0}));
    repeat (20) @(negedge init_clk);
    check("nolock_fail_sticky", 32'({fail, pll_rst}), 32'({1'b1, 1'b0}));

    // Lock only with icpsel==3: one timeout, then lock at cycle 4+16+4+10.
    rstn   = 1'b0;
    follow = 1'b1;
    @(negedge init_clk);
    rstn = 1'b1;
    wait_lock_val(1'b1, 100, "icp3", n);
    check("icp3_lock_cycle", 32'(n), 32'd34);
    check("icp3_icpsel", 32'(icpsel), 32'd3);
    check("icp3_flags", 32'({user_rst_n, fail}), 32'({1'b1, 1'b0}));

    // One-cycle glitch during STABLE restarts with icpsel unchanged.
    rstn         = 1'b0;
    follow       = 1'b0;
    pll_lock_man = 1'b0;
    @(negedge init_clk);
    rstn = 1'b1;
    measure_pulse("glitch_first", w, icp);
    check("glitch_first_width", 32'(w), 32'd4);
    pll_lock_man = 1'b1;
    repeat (5) @(negedge init_clk);
    pll_lock_man = 1'b0;
    @(negedge init_clk);
    pll_lock_man = 1'b1;
    measure_pulse("glitch", w, icp);
    check("glitch_width", 32'(w), 32'd4);
    check("glitch_icp", 32'(icp), 32'd2);
    check("glitch_lock", 32'(lock), 32'd0);

    // Lock losses: 3-cycle reaction, then relock_cnt saturation.
    wait_lock_val(1'b1, 60, "relock_init", n);
    for (int k = 0; k < 260; k++) begin
      pll_lock_man = 1'b0;
      wait_lock_val(1'b0, 10, "loss", n);
      if (k == 0) begin
        check("loss_latency", 32'(n), 32'd3);
        check("loss_urn", 32'(user_rst_n), 32'd0);
        check("loss_cnt1", 32'(relock_cnt), 32'd1);
      end
      if (k == 254) check("loss_cnt255", 32'(relock_cnt), 32'd255);
      pll_lock_man = 1'b1;
      wait_lock_val(1'b1, 60, "relock", n);
    end
    check("loss_cnt_sat", 32'(relock_cnt), 32'd255);

    // Async reset in the middle of the icpsel==3 WAIT_LOCK.
    pll_lock_man = 1'b0;
    guard = 0;
    while (!(icpsel == 6'd3 && pll_rst == 1'b0) && guard < 100) begin
      @(negedge init_clk);
      guard++;
    end
    repeat (3) @(negedge init_clk);
    check("midwait_pre", 32'({icpsel, pll_rst, relock_cnt}), 32'({6'd3, 1'b0, 8'd255}));
    rstn = 1'b0;
    #1;
    check("midwait_rst", 32'({pll_rst, icpsel, lock, user_rst_n, fail, relock_cnt}),
          32'({1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 8'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
